// File: rtl/nios2_mul_seq_ctrl.sv
// Builds a 32x32 product from four passes through one shared 16x16 pipelined multiplier,
// then applies the Nios II signed correction (MUL/MULXSS/MULXSU/MULXUU) to the upper word.
module nios2_mul_seq_ctrl #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_prod,
  output logic [31:0] out_result,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, CORRECT, DONE} state_t;

  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_XSS = 2'd1;
  localparam logic [1:0] OP_XSU = 2'd2;

  state_t      state_q;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [1:0]  cnt_q, dcnt_q;
  logic [63:0] acc_q, prod_q;
  logic [31:0] res_q;

  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p;
  logic [1:0]  mul_sft;
  logic [63:0] pp_ext;
  logic [31:0] hi_d;

  logic [31:0] pp_q  [MUL_LATENCY];
  logic [1:0]  sft_q [MUL_LATENCY];
  logic        vld_q [MUL_LATENCY];

  // cnt 0..3 selects LL, HL, LH, HH; shift in units of 16 is the number of high halves used
  assign mul_a   = cnt_q[0] ? a_q[31:16] : a_q[15:0];
  assign mul_b   = cnt_q[1] ? b_q[31:16] : b_q[15:0];
  assign mul_p   = {16'b0, mul_a} * {16'b0, mul_b};
  assign mul_sft = {1'b0, cnt_q[0]} + {1'b0, cnt_q[1]};
  assign pp_ext  = {32'b0, pp_q[MUL_LATENCY-1]} << {sft_q[MUL_LATENCY-1], 4'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        pp_q[i]  <= '0;
        sft_q[i] <= '0;
        vld_q[i] <= 1'b0;
      end
    end else begin
      pp_q[0]  <= mul_p;
      sft_q[0] <= mul_sft;
      vld_q[0] <= (state_q == ISSUE);
      for (int i = 1; i < MUL_LATENCY; i++) begin
        pp_q[i]  <= pp_q[i-1];
        sft_q[i] <= sft_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  always_comb begin
    hi_d = acc_q[63:32];
    if (op_q == OP_XSS) begin
      if (a_q[31]) hi_d = hi_d - b_q;
      if (b_q[31]) hi_d = hi_d - a_q;
    end else if (op_q == OP_XSU) begin
      if (a_q[31]) hi_d = hi_d - b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      res_q   <= '0;
    end else begin
      if (vld_q[MUL_LATENCY-1]) acc_q <= acc_q + pp_ext;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= in_op;
            a_q     <= in_src1;
            b_q     <= in_src2;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            dcnt_q  <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          dcnt_q <= dcnt_q + 2'd1;
          if (dcnt_q == 2'(MUL_LATENCY - 1)) state_q <= CORRECT;
        end
        CORRECT: begin
          prod_q  <= {hi_d, acc_q[31:0]};
          res_q   <= (op_q == OP_MUL) ? acc_q[31:0] : hi_d;
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE) && !reset;
  assign busy       = (state_q != IDLE) && !reset;
  assign out_valid  = (state_q == DONE) && !reset;
  assign out_prod   = prod_q;
  assign out_result = res_q;

endmodule

// File: tb/tb_nios2_mul_seq_ctrl.sv
// Directed bench for nios2_mul_seq_ctrl; instance 0 uses MUL_LATENCY=1, instance 1 uses MUL_LATENCY=3.
module tb_nios2_mul_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset      [2];
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [1:0]  in_op      [2];
  logic [31:0] in_src1    [2];
  logic [31:0] in_src2    [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [63:0] out_prod   [2];
  logic [31:0] out_result [2];
  logic        busy       [2];

  int n_cmp = 0;
  int n_bad = 0;

  nios2_mul_seq_ctrl #(.MUL_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_op(in_op[0]), .in_src1(in_src1[0]), .in_src2(in_src2[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_prod(out_prod[0]),
    .out_result(out_result[0]), .busy(busy[0])
  );

  nios2_mul_seq_ctrl #(.MUL_LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_op(in_op[1]), .in_src1(in_src1[1]), .in_src2(in_src2[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_prod(out_prod[1]),
    .out_result(out_result[1]), .busy(busy[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op; lat is cycles from the accept cycle T to the first out_valid cycle.
  task automatic do_op(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [63:0] prod, output logic [31:0] res,
                       output logic busy_t1, output logic idle_after);
    int w = 0;
    while (!in_ready[d] && w < 20) begin step(); w++; end
    in_valid[d] = 1'b1; in_op[d] = op; in_src1[d] = a; in_src2[d] = b;
    step();
    in_valid[d] = 1'b0; in_op[d] = ~op; in_src1[d] = 32'hDEAD_BEEF; in_src2[d] = 32'h1234_5678;
    busy_t1 = busy[d] && !in_ready[d];
    lat = 1;
    while (!out_valid[d] && lat < 40) begin step(); lat++; end
    prod = out_prod[d];
    res  = out_result[d];
    idle_after = 1'b0;
    if (out_ready[d]) begin
      step();
      idle_after = !out_valid[d] && in_ready[d] && !busy[d];
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) reset[d] = 1'b1;
    step(); step();
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (in_ready[d] !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready d%0d: got %b want 0", d, in_ready[d]); end
      n_cmp++; if (out_valid[d] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid d%0d: got %b want 0", d, out_valid[d]); end
      n_cmp++; if (busy[d] !== 1'b0) begin n_bad++; $display("FAIL reset_busy d%0d: got %b want 0", d, busy[d]); end
      n_cmp++; if (out_prod[d] !== 64'h0) begin n_bad++; $display("FAIL reset_out_prod d%0d: got %h want 0", d, out_prod[d]); end
      n_cmp++; if (out_result[d] !== 32'h0) begin n_bad++; $display("FAIL reset_out_result d%0d: got %h want 0", d, out_result[d]); end
    end
    for (int d = 0; d < 2; d++) reset[d] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (in_ready[d] !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready d%0d: got %b want 1", d, in_ready[d]); end
    end
  endtask

  task automatic test_mulxuu(input int d);
    int lat; logic [63:0] p; logic [31:0] r; logic b1, ia;
    do_op(d, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, p, r, b1, ia);
    n_cmp++; if (lat !== (d == 0 ? 7 : 9)) begin n_bad++; $display("FAIL xuu_latency d%0d: got %0d want %0d", d, lat, (d == 0 ? 7 : 9)); end
    n_cmp++; if (p !== 64'hFFFF_FFFE_0000_0001) begin n_bad++; $display("FAIL xuu_prod d%0d: got %h want fffffffe00000001", d, p); end
    n_cmp++; if (r !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL xuu_result d%0d: got %h want fffffffe", d, r); end
    n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL xuu_busy_t1 d%0d: got %b want 1", d, b1); end
    n_cmp++; if (ia !== 1'b1) begin n_bad++; $display("FAIL xuu_idle_after d%0d: got %b want 1", d, ia); end
  endtask

  task automatic test_mulxss(input int d);
    int lat; logic [63:0] p; logic [31:0] r; logic b1, ia;
    do_op(d, 2'd1, 32'hFFFF_FFFF, 32'h0000_0002, lat, p, r, b1, ia);
    n_cmp++; if (lat !== (d == 0 ? 7 : 9)) begin n_bad++; $display("FAIL xss_latency d%0d: got %0d want %0d", d, lat, (d == 0 ? 7 : 9)); end
    n_cmp++; if (p !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_bad++; $display("FAIL xss_prod d%0d: got %h want fffffffffffffffe", d, p); end
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL xss_result d%0d: got %h want ffffffff", d, r); end
  endtask

  task automatic test_mulxsu(input int d);
    int lat; logic [63:0] p; logic [31:0] r; logic b1, ia;
    do_op(d, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, p, r, b1, ia);
    n_cmp++; if (lat !== (d == 0 ? 7 : 9)) begin n_bad++; $display("FAIL xsu_latency d%0d: got %0d want %0d", d, lat, (d == 0 ? 7 : 9)); end
    n_cmp++; if (p !== 64'h8000_0000_8000_0000) begin n_bad++; $display("FAIL xsu_prod d%0d: got %h want 8000000080000000", d, p); end
    n_cmp++; if (r !== 32'h8000_0000) begin n_bad++; $display("FAIL xsu_result d%0d: got %h want 80000000", d, r); end
  endtask

  task automatic test_mul(input int d);
    int lat; logic [63:0] p; logic [31:0] r; logic b1, ia;
    do_op(d, 2'd0, 32'h0001_2345, 32'h0001_0000, lat, p, r, b1, ia);
    n_cmp++; if (lat !== (d == 0 ? 7 : 9)) begin n_bad++; $display("FAIL mul_latency d%0d: got %0d want %0d", d, lat, (d == 0 ? 7 : 9)); end
    n_cmp++; if (p !== 64'h0000_0001_2345_0000) begin n_bad++; $display("FAIL mul_prod d%0d: got %h want 0000000123450000", d, p); end
    n_cmp++; if (r !== 32'h2345_0000) begin n_bad++; $display("FAIL mul_result d%0d: got %h want 23450000", d, r); end
  endtask

  task automatic test_out_stall(input int d);
    int lat; logic [63:0] p; logic [31:0] r; logic b1, ia;
    out_ready[d] = 1'b0;
    do_op(d, 2'd3, 32'h0001_0001, 32'h0001_0001, lat, p, r, b1, ia);
    n_cmp++; if (p !== 64'h0000_0001_0002_0001) begin n_bad++; $display("FAIL stall_prod d%0d: got %h want 0000000100020001", d, p); end
    n_cmp++; if (r !== 32'h0000_0001) begin n_bad++; $display("FAIL stall_result d%0d: got %h want 00000001", d, r); end
    for (int i = 0; i < 5; i++) begin
      in_valid[d] = 1'b1; in_op[d] = 2'd0; in_src1[d] = 32'h0000_0007 + i; in_src2[d] = 32'h0000_0009;
      step();
      n_cmp++; if (out_valid[d] !== 1'b1) begin n_bad++; $display("FAIL stall_out_valid d%0d c%0d: got %b want 1", d, i, out_valid[d]); end
      n_cmp++; if (in_ready[d] !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready d%0d c%0d: got %b want 0", d, i, in_ready[d]); end
      n_cmp++; if (out_prod[d] !== 64'h0000_0001_0002_0001) begin n_bad++; $display("FAIL stall_hold_prod d%0d c%0d: got %h want 0000000100020001", d, i, out_prod[d]); end
      n_cmp++; if (out_result[d] !== 32'h0000_0001) begin n_bad++; $display("FAIL stall_hold_result d%0d c%0d: got %h want 00000001", d, i, out_result[d]); end
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    step();
    n_cmp++; if (out_valid[d] !== 1'b0) begin n_bad++; $display("FAIL stall_release_valid d%0d: got %b want 0", d, out_valid[d]); end
    n_cmp++; if (in_ready[d] !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready d%0d: got %b want 1", d, in_ready[d]); end
    n_cmp++; if (busy[d] !== 1'b0) begin n_bad++; $display("FAIL stall_release_busy d%0d: got %b want 0", d, busy[d]); end
  endtask

  task automatic test_reset_abort(input int d);
    int lat; logic [63:0] p; logic [31:0] r; logic b1, ia;
    int w = 0;
    while (!in_ready[d] && w < 20) begin step(); w++; end
    in_valid[d] = 1'b1; in_op[d] = 2'd3; in_src1[d] = 32'hFFFF_FFFF; in_src2[d] = 32'hFFFF_FFFF;
    step();
    in_valid[d] = 1'b0;
    step(); step();
    reset[d] = 1'b1;
    step();
    n_cmp++; if (busy[d] !== 1'b0) begin n_bad++; $display("FAIL abort_busy d%0d: got %b want 0", d, busy[d]); end
    n_cmp++; if (out_valid[d] !== 1'b0) begin n_bad++; $display("FAIL abort_out_valid d%0d: got %b want 0", d, out_valid[d]); end
    reset[d] = 1'b0;
    do_op(d, 2'd1, 32'h0000_0003, 32'hFFFF_FFFD, lat, p, r, b1, ia);
    n_cmp++; if (lat !== (d == 0 ? 7 : 9)) begin n_bad++; $display("FAIL abort_latency d%0d: got %0d want %0d", d, lat, (d == 0 ? 7 : 9)); end
    n_cmp++; if (p !== 64'hFFFF_FFFF_FFFF_FFF7) begin n_bad++; $display("FAIL abort_prod d%0d: got %h want fffffffffffffff7", d, p); end
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL abort_result d%0d: got %h want ffffffff", d, r); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; in_valid[d] = 1'b0; in_op[d] = 2'd0;
      in_src1[d] = 32'h0; in_src2[d] = 32'h0; out_ready[d] = 1'b1;
    end
    test_reset();
    test_mulxuu(0);
    test_mulxss(0);
    test_mulxsu(0);
    test_mul(0);
    test_out_stall(0);
    test_mul(0);
    test_reset_abort(0);
    test_mulxuu(1);
    test_mulxss(1);
    test_mulxsu(1);
    test_reset_abort(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
